// File: rtl/level_sensitive_dlatch_pkg.sv
// Shared constants and helpers for the synchronous latch-emulation bank.
package level_sensitive_dlatch_pkg;

    typedef enum logic {
        EnActiveLow  = 1'b0,
        EnActiveHigh = 1'b1
    } en_pol_e;

    localparam int unsigned DefaultWidth        = 1;
    localparam int unsigned DefaultLanes        = 1;
    localparam int unsigned DefaultResetValue   = 0;
    localparam bit          DefaultEnActiveHigh = 1'b1;

    // Low bit of a lane's slice within the packed D/Q vectors.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic logic en_decode(input logic en, input en_pol_e pol);
        return (pol == EnActiveHigh) ? en : ~en;
    endfunction

endpackage

// File: rtl/level_sensitive_dlatch_if.sv
// Data/enable bundle for the latch bank; master drives D/En, slave returns Q and status.
interface level_sensitive_dlatch_if
    import level_sensitive_dlatch_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned LANES = DefaultLanes
);

    logic [LANES*WIDTH-1:0] D;
    logic [LANES-1:0]       En;
    logic [LANES*WIDTH-1:0] Q;
    logic [LANES-1:0]       transparent;
    logic [LANES-1:0]       q_changed;

    modport master (
        output D,
        output En,
        input  Q,
        input  transparent,
        input  q_changed
    );

    modport slave (
        input  D,
        input  En,
        output Q,
        output transparent,
        output q_changed
    );

endinterface

// File: rtl/level_sensitive_dlatch_lane.sv
// One latch lane (dlatch_lane): enable decode, hold register, output mux and change detect.
module level_sensitive_dlatch_lane
    import level_sensitive_dlatch_pkg::*;
#(
    parameter int unsigned      WIDTH          = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter bit               EN_ACTIVE_HIGH = DefaultEnActiveHigh
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             transparent,
    output logic             q_changed
);

    localparam en_pol_e Pol = en_pol_e'(EN_ACTIVE_HIGH);

    logic             en_eff;
    logic [WIDTH-1:0] hold_d;
    logic [WIDTH-1:0] hold_q;
    logic             q_changed_q;

    always_comb begin
        en_eff = en_decode(en, Pol);
        hold_d = hold_q;
        if (en_eff) begin
            hold_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= RESET_VALUE;
            q_changed_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            q_changed_q <= (hold_d != hold_q);
        end
    end

    // Open lane passes D straight through; closed lane replays the last enabled sample.
    always_comb begin
        q           = en_eff ? d : hold_q;
        transparent = en_eff;
        q_changed   = q_changed_q;
    end

endmodule

// File: rtl/level_sensitive_dlatch.sv
// Bank of LANES latch lanes; only packs and unpacks the lane slices.
module level_sensitive_dlatch
    import level_sensitive_dlatch_pkg::*;
#(
    parameter int unsigned      WIDTH          = DefaultWidth,
    parameter int unsigned      LANES          = DefaultLanes,
    parameter logic [WIDTH-1:0] RESET_VALUE    = WIDTH'(DefaultResetValue),
    parameter bit               EN_ACTIVE_HIGH = DefaultEnActiveHigh
) (
    input logic                     clk,
    input logic                     rst,
    level_sensitive_dlatch_if.slave bus
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        level_sensitive_dlatch_lane #(
            .WIDTH          (WIDTH),
            .RESET_VALUE    (RESET_VALUE),
            .EN_ACTIVE_HIGH (EN_ACTIVE_HIGH)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .d           (bus.D[lane_lsb(i, WIDTH) +: WIDTH]),
            .en          (bus.En[i]),
            .q           (bus.Q[lane_lsb(i, WIDTH) +: WIDTH]),
            .transparent (bus.transparent[i]),
            .q_changed   (bus.q_changed[i])
        );
    end

endmodule

// File: tb/tb_level_sensitive_dlatch.sv
// Directed bench: three configurations (1x1 active-high, 4x8 active-high, 1x8 active-low).
module tb_level_sensitive_dlatch;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    level_sensitive_dlatch_if #(.WIDTH(1), .LANES(1)) bus0 ();
    level_sensitive_dlatch_if #(.WIDTH(8), .LANES(4)) bus1 ();
    level_sensitive_dlatch_if #(.WIDTH(8), .LANES(1)) bus2 ();

    level_sensitive_dlatch #(
        .WIDTH(1), .LANES(1), .RESET_VALUE(1'b0), .EN_ACTIVE_HIGH(1'b1)
    ) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));

    level_sensitive_dlatch #(
        .WIDTH(8), .LANES(4), .RESET_VALUE(8'h5A), .EN_ACTIVE_HIGH(1'b1)
    ) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    level_sensitive_dlatch #(
        .WIDTH(8), .LANES(1), .RESET_VALUE(8'h0F), .EN_ACTIVE_HIGH(1'b0)
    ) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bus0.D = '0; bus0.En = 1'b0;
        bus1.D = '0; bus1.En = 4'b0000;
        bus2.D = '0; bus2.En = 1'b1;
        repeat (2) step();
        tests_run++;
        if (bus0.Q !== 1'b0) begin
            tests_failed++; $display("FAIL reset_q0: got %b want 0", bus0.Q);
        end
        tests_run++;
        if (bus0.q_changed !== 1'b0 || bus0.transparent !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status0: q_changed %b transparent %b want 0 0",
                     bus0.q_changed, bus0.transparent);
        end
        tests_run++;
        if (bus1.Q !== 32'h5A5A5A5A || bus1.q_changed !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_q1: Q %h q_changed %b want 5a5a5a5a 0000",
                     bus1.Q, bus1.q_changed);
        end
        tests_run++;
        if (bus2.Q !== 8'h0F) begin
            tests_failed++; $display("FAIL reset_q2: got %h want 0f", bus2.Q);
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (bus0.Q !== 1'b0) begin
                tests_failed++; $display("FAIL post_reset_hold[%0d]: got %b want 0", i, bus0.Q);
            end
        end
    endtask

    task automatic test_transparency();
        bus0.En = 1'b1; bus0.D = 1'b0;
        #1;
        tests_run++;
        if (bus0.Q !== 1'b0 || bus0.transparent !== 1'b1) begin
            tests_failed++;
            $display("FAIL transp_d0: Q %b transparent %b want 0 1", bus0.Q, bus0.transparent);
        end
        bus0.D = 1'b1;
        #1;
        tests_run++;
        if (bus0.Q !== 1'b1) begin
            tests_failed++; $display("FAIL transp_d1: got %b want 1", bus0.Q);
        end
        bus0.D = 1'b0;
        #1;
        tests_run++;
        if (bus0.Q !== 1'b0) begin
            tests_failed++; $display("FAIL transp_d0b: got %b want 0", bus0.Q);
        end
        step();
    endtask

    task automatic test_hold();
        bus0.D = 1'b1;
        step();
        tests_run++;
        if (bus0.q_changed !== 1'b1) begin
            tests_failed++; $display("FAIL hold_capture_pulse: got %b want 1", bus0.q_changed);
        end
        bus0.En = 1'b0;
        #1;
        tests_run++;
        if (bus0.Q !== 1'b1 || bus0.transparent !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_close: Q %b transparent %b want 1 0", bus0.Q, bus0.transparent);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            bus0.D = ~bus0.D;
            #1;
            tests_run++;
            if (bus0.Q !== 1'b1 || bus0.q_changed !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_toggle[%0d]: Q %b q_changed %b want 1 0",
                         i, bus0.Q, bus0.q_changed);
            end
            step();
        end
    endtask

    task automatic test_periodic();
        logic hold_exp = 1'b1;
        logic en_v, d_v, q_exp;
        for (int k = 0; k < 100; k++) begin
            en_v = ((k / 10) % 2) == 1;
            d_v  = ((k / 20) % 2) == 1;
            bus0.En = en_v;
            bus0.D  = d_v;
            #1;
            q_exp = en_v ? d_v : hold_exp;
            tests_run++;
            if (bus0.Q !== q_exp) begin
                tests_failed++;
                $display("FAIL periodic[%0d]: got %b want %b (En %b D %b)",
                         k, bus0.Q, q_exp, en_v, d_v);
            end
            if (en_v) hold_exp = d_v;
            step();
        end
    endtask

    task automatic test_multi_lane();
        bus1.D  = 32'h44332211;
        bus1.En = 4'b0101;
        #1;
        tests_run++;
        if (bus1.Q !== 32'h5A335A11 || bus1.transparent !== 4'b0101) begin
            tests_failed++;
            $display("FAIL multi_open: Q %h transparent %b want 5a335a11 0101",
                     bus1.Q, bus1.transparent);
        end
        step();
        tests_run++;
        if (bus1.q_changed !== 4'b0101) begin
            tests_failed++; $display("FAIL multi_pulse: got %b want 0101", bus1.q_changed);
        end
        bus1.En = 4'b0000;
        bus1.D  = 32'hFFFFFFFF;
        #1;
        tests_run++;
        if (bus1.Q !== 32'h5A335A11) begin
            tests_failed++; $display("FAIL multi_closed: got %h want 5a335a11", bus1.Q);
        end
        step();
        tests_run++;
        if (bus1.q_changed !== 4'b0000 || bus1.Q !== 32'h5A335A11) begin
            tests_failed++;
            $display("FAIL multi_settle: q_changed %b Q %h want 0000 5a335a11",
                     bus1.q_changed, bus1.Q);
        end
    endtask

    task automatic test_back_to_back();
        bus1.En = 4'b0010;
        bus1.D  = 32'h00000100;
        step();
        tests_run++;
        if (bus1.q_changed !== 4'b0010) begin
            tests_failed++; $display("FAIL b2b_first: got %b want 0010", bus1.q_changed);
        end
        bus1.D = 32'h00000200;
        step();
        tests_run++;
        if (bus1.q_changed !== 4'b0010) begin
            tests_failed++; $display("FAIL b2b_second: got %b want 0010", bus1.q_changed);
        end
        step();
        tests_run++;
        if (bus1.q_changed !== 4'b0000) begin
            tests_failed++; $display("FAIL b2b_same: got %b want 0000", bus1.q_changed);
        end
        bus1.En = 4'b0000;
        #1;
        tests_run++;
        if (bus1.Q !== 32'h5A330211) begin
            tests_failed++; $display("FAIL b2b_hold: got %h want 5a330211", bus1.Q);
        end
    endtask

    task automatic test_polarity_reset();
        bus2.En = 1'b0;
        bus2.D  = 8'hA5;
        #1;
        tests_run++;
        if (bus2.Q !== 8'hA5 || bus2.transparent !== 1'b1) begin
            tests_failed++;
            $display("FAIL pol_open: Q %h transparent %b want a5 1", bus2.Q, bus2.transparent);
        end
        step();
        bus2.En = 1'b1;
        bus2.D  = 8'h00;
        #1;
        tests_run++;
        if (bus2.Q !== 8'hA5 || bus2.transparent !== 1'b0) begin
            tests_failed++;
            $display("FAIL pol_hold: Q %h transparent %b want a5 0", bus2.Q, bus2.transparent);
        end
        step();
        rst2 = 1'b1;
        #1;
        tests_run++;
        if (bus2.Q !== 8'hA5) begin
            tests_failed++; $display("FAIL pol_rst_pre_edge: got %h want a5", bus2.Q);
        end
        step();
        rst2 = 1'b0;
        tests_run++;
        if (bus2.Q !== 8'h0F || bus2.q_changed !== 1'b0) begin
            tests_failed++;
            $display("FAIL pol_rst_mid_hold: Q %h q_changed %b want 0f 0", bus2.Q, bus2.q_changed);
        end
        bus2.En = 1'b0;
        bus2.D  = 8'h3C;
        #1;
        tests_run++;
        if (bus2.Q !== 8'h3C || bus2.transparent !== 1'b1) begin
            tests_failed++;
            $display("FAIL pol_reopen: Q %h transparent %b want 3c 1", bus2.Q, bus2.transparent);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_transparency();
        test_hold();
        test_periodic();
        test_multi_lane();
        test_back_to_back();
        test_polarity_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
